// File: rtl/fmap_stream_tx_if.sv
// rtl/fmap_stream_tx_if.sv - activation beat stream from the feature-map streamer to the conv layer
interface fmap_stream_tx_if #(
  parameter int ACTIVATION_BITS = 8
);
  logic [ACTIVATION_BITS-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_eol;
  logic                       out_last;

  modport master (output out_data, output out_valid, output out_eol, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_eol, input out_last, output out_ready);
endinterface

// File: rtl/fmap_stream_tx.sv
// rtl/fmap_stream_tx.sv - INT8 feature-map reader with zero-pad insertion feeding a valid/ready stream
module fmap_stream_tx #(
  parameter int ACTIVATION_BITS = 8,
  parameter int ADDR_BITS       = 18,
  parameter int DIM_BITS        = 10,
  parameter int CH_BITS         = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDR_BITS-1:0]       cfg_base_addr,
  input  logic [DIM_BITS-1:0]        cfg_width,
  input  logic [DIM_BITS-1:0]        cfg_height,
  input  logic [CH_BITS-1:0]         cfg_channels,
  input  logic [1:0]                 cfg_padding,
  output logic                       busy,
  output logic                       done,
  output logic                       mem_rd_en,
  output logic [ADDR_BITS-1:0]       mem_addr,
  input  logic [ACTIVATION_BITS-1:0] mem_rdata,
  fmap_stream_tx_if.master           out_if
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  // padded coordinates need one extra bit: W + 2P can exceed 2^DIM_BITS - 1
  localparam int PB = DIM_BITS + 1;

  logic [1:0]           state;
  logic [ADDR_BITS-1:0] next_addr;
  logic [DIM_BITS-1:0]  w_q, h_q;
  logic [CH_BITS-1:0]   c_q, ch;
  logic [1:0]           p_q;
  logic [PB-1:0]        px, py;

  logic pipe_valid, pipe_pad, pipe_eol, pipe_last;

  logic [ACTIVATION_BITS-1:0] fifo_data [4];
  logic [3:0]                 fifo_eol, fifo_last;
  logic [1:0]                 wr_ptr, rd_ptr;
  logic [2:0]                 count;

  logic [PB-1:0] pad_w, w_tot_m1, h_tot_m1;
  logic          x_real, y_real, is_real, x_end, y_end, c_end, el_last;
  logic          credit_ok, issue, push, pop;

  always_comb begin
    pad_w    = PB'(p_q);
    w_tot_m1 = PB'(w_q) + (pad_w << 1) - PB'(1);
    h_tot_m1 = PB'(h_q) + (pad_w << 1) - PB'(1);
    x_real   = (px >= pad_w) && (px < pad_w + PB'(w_q));
    y_real   = (py >= pad_w) && (py < pad_w + PB'(h_q));
    is_real  = x_real && y_real;
    x_end    = (px == w_tot_m1);
    y_end    = (py == h_tot_m1);
    c_end    = (ch == c_q - CH_BITS'(1));
    el_last  = x_end && y_end && c_end;
  end

  // every issued element holds a FIFO slot from issue onward, so a push never hits a full FIFO
  assign credit_ok = ({1'b0, count} + {3'b000, pipe_valid}) < 4'd4;
  assign issue     = (state == S_RUN) && credit_ok;
  assign mem_rd_en = issue && is_real;
  assign mem_addr  = mem_rd_en ? next_addr : '0;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_FIN);

  assign out_if.out_valid = (count != 3'd0);
  assign out_if.out_data  = out_if.out_valid ? fifo_data[rd_ptr] : '0;
  assign out_if.out_eol   = out_if.out_valid && fifo_eol[rd_ptr];
  assign out_if.out_last  = out_if.out_valid && fifo_last[rd_ptr];

  assign push = pipe_valid;
  assign pop  = out_if.out_valid && out_if.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      next_addr  <= '0;
      w_q        <= '0;
      h_q        <= '0;
      c_q        <= '0;
      p_q        <= '0;
      px         <= '0;
      py         <= '0;
      ch         <= '0;
      pipe_valid <= 1'b0;
      pipe_pad   <= 1'b0;
      pipe_eol   <= 1'b0;
      pipe_last  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_eol   <= '0;
      fifo_last  <= '0;
      for (int i = 0; i < 4; i++) fifo_data[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            next_addr <= cfg_base_addr;
            w_q       <= cfg_width;
            h_q       <= cfg_height;
            c_q       <= cfg_channels;
            p_q       <= cfg_padding;
            px        <= '0;
            py        <= '0;
            ch        <= '0;
            if (cfg_width == '0 || cfg_height == '0 || cfg_channels == '0) state <= S_FIN;
            else state <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            // real elements are visited in memory order, so one running pointer gives the address
            if (is_real) next_addr <= next_addr + ADDR_BITS'(1);
            if (x_end) begin
              px <= '0;
              if (y_end) begin
                py <= '0;
                ch <= ch + CH_BITS'(1);
              end else begin
                py <= py + PB'(1);
              end
            end else begin
              px <= px + PB'(1);
            end
            if (el_last) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!pipe_valid && (count == 3'd0 || (count == 3'd1 && pop))) state <= S_FIN;
        end
        default: state <= S_IDLE;
      endcase

      pipe_valid <= issue;
      pipe_pad   <= !is_real;
      pipe_eol   <= x_end;
      pipe_last  <= el_last;

      if (push) begin
        fifo_data[wr_ptr] <= pipe_pad ? '0 : mem_rdata;
        fifo_eol[wr_ptr]  <= pipe_eol;
        fifo_last[wr_ptr] <= pipe_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

endmodule

// File: doc/fmap_stream_tx.md
Name: fmap_stream_tx

Overview:
- Feature-map streamer that feeds the activation input port of the convolution layer.
- Reads an INT8 activation tensor from an on-chip feature-map RAM and inserts zero padding.
- Transmits one activation per beat over a valid/ready stream: channel-major, then row, then column, padded borders included.
- Sits between the feature-map BRAM and the convolution input port (data/valid/ready).

Parameters:
- ACTIVATION_BITS, 8, width of one activation word and of mem_rdata.
- ADDR_BITS, 18, feature-map RAM word-address width.
- DIM_BITS, 10, width of cfg_width and cfg_height.
- CH_BITS, 8, width of cfg_channels.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle request; accepted only when idle
- cfg_base_addr  in  ADDR_BITS  word address of channel 0, row 0, column 0
- cfg_width  in  DIM_BITS  unpadded columns W
- cfg_height  in  DIM_BITS  unpadded rows H
- cfg_channels  in  CH_BITS  channel count C
- cfg_padding  in  2  border width P (0..3)
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last beat is accepted
- mem_rd_en  out  1  RAM read strobe
- mem_addr  out  ADDR_BITS  RAM read address
- mem_rdata  in  ACTIVATION_BITS  read data, valid exactly 1 cycle after mem_rd_en
- out_data  out  ACTIVATION_BITS  activation to the conv layer
- out_valid  out  1  beat valid
- out_ready  in  1  conv layer accepts the beat
- out_eol  out  1  beat is the last column of a padded row
- out_last  out  1  beat is the final beat of the tensor

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: busy=0, done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_data=0, out_eol=0, out_last=0. Reset also clears the FIFO, the in-flight count and all counters.
- Configuration capture: all cfg_* are registered on start acceptance and ignored afterwards. start while busy is ignored.
- State IDLE: start moves to RUN. If W, H or C is 0, go instead to FIN: no reads, no beats, done pulses the cycle after start.
- State RUN: issue one element per cycle while (fifo_count + inflight) < 4.
  - Element order: c from 0 to C-1; y from -P to H+P-1; x from -P to W+P-1.
- Real element (0≤x<W, 0≤y<H):
  - mem_rd_en=1 and mem_addr = base + c*W*H + y*W + x.
  - Compute the address incrementally (row and channel base registers); no multiplier in the issue path.
- Pad element: mem_rd_en=0 and a pad tag enters the 1-cycle pipeline, so real and pad elements keep the same timing.
- FIFO write: one cycle after issue, the element enters a 4-entry FIFO as {data or 0, eol, last}. This preserves order.
- Once the final element has been issued, move to DRAIN.
- State DRAIN: no issue. Wait until the FIFO is empty and inflight is 0, then go to FIN.
- State FIN: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Output handshake:
  - out_valid = FIFO not empty; out_data/out_eol/out_last = FIFO head.
  - A beat transfers when out_valid & out_ready.
  - While stalled, out_data/out_eol/out_last stay stable.
  - out_valid never drops without a transfer.
- Latency: start accepted at cycle 0 → first issue at cycle 1 → out_valid at cycle 3.
- Throughput: 1 beat per cycle with out_ready held high.
- Beat count: exactly C*(H+2P)*(W+2P) beats.
- out_eol: asserted on x=W+P-1.
- out_last: asserted only on the final beat, together with its out_eol.
- Simultaneous FIFO push and pop: both take effect; the count is unchanged.
- Credit rule: a push never occurs while the FIFO is full.
- Address arithmetic: wraps modulo 2^ADDR_BITS with no error flag. Padding never generates an address.
- rst mid-operation: everything returns to reset values next cycle and pending beats are discarded. mem_rdata arriving after rst is ignored.

Test Plan:
- W=4, H=2, C=1, P=0, base=0, mem[i]=i+1, out_ready=1 → 8 beats 1..8 on consecutive cycles; first out_valid 3 cycles after start; out_eol on beats 4 and 8; out_last on beat 8; done the cycle after beat 8.
- W=2, H=2, C=1, P=1, mem={10,20,30,40} → 16 beats: 0,0,0,0, 0,10,20,0, 0,30,40,0, 0,0,0,0; exactly 4 reads at addresses 0,1,2,3; out_eol every 4th beat.
- W=3, H=1, C=2, P=0, base=100 → reads at 100..105 in order; 6 beats; out_last only on beat 6.
- Case 3 with out_ready toggled pseudo-randomly (50%) → identical beat sequence; data stable while stalled; FIFO never overflows; mem_rd_en=0 whenever 4 credits are used.
- cfg_height=0 → done 1 cycle after start; no mem_rd_en; no out_valid. A second start while busy in case 1 → ignored; still 8 beats.
- rst asserted after beat 3 of case 1 → next cycle all outputs are 0; a fresh start gives a full 8-beat sequence from value 1.
